uart_receiver: RTL and testbench
================================

# uart_receiver

Receive-side UART for the miner's host link, and the counterpart of the existing transmitter. It samples the asynchronous `uart_rx` pin in the single `clk` domain and deframes 8N1 characters (1 start bit, 8 data bits LSB first, 1 stop bit). Each received byte is presented as a one-cycle pulse on `tx_new_byte` with the data on `tx_byte`, for the command parser. Line errors are reported and recovered from without host intervention.

## Interface
- `comm_clk_frequency`, default 75000000: clk frequency in Hz.
- `baud_rate`, default 115200: line rate in bit/s.
- Derived `baud_delay` = comm_clk_frequency/baud_rate − 1, 16 bits (default 650); bit period B = baud_delay+1 clocks.
- Derived `half_delay` = baud_delay/2, integer division (default 325).
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial line; idles high.
- `tx_new_byte`  out  1  one-cycle pulse: `tx_byte` holds a valid new byte.
- `tx_byte`  out  8  last good byte received; holds its value between pulses.
- `framing_error`  out  1  one-cycle pulse: the stop bit was sampled low.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Synchroniser: `uart_rx` passes through 2 flops, both reset to 1. Only the second flop (`rx_s`) is used; a pin edge is visible in `rx_s` 2 cycles later.
- Counters:
  - `cnt`, 16 bits; cleared on every state transition, otherwise +1 per clk.
  - `bit_idx`, 3 bits.
  - `shift`, 8 bits; new bits enter at [7] and shift right, so bit 0 ends in [0].
- IDLE:
  - `rx_s`=0 → START, cnt=0. This cycle is t0.
- START:
  - At cnt==half_delay: `rx_s`=0 → DATA, bit_idx=0.
  - At cnt==half_delay: `rx_s`=1 → IDLE. This is a glitch; no output.
- DATA:
  - At cnt==baud_delay: shift in `rx_s`.
  - If bit_idx==7 → STOP, else bit_idx+1.
- STOP, at cnt==baud_delay:
  - `rx_s`=1: next cycle `tx_byte`←shift, `tx_new_byte`=1; go to IDLE.
  - `rx_s`=0: next cycle `framing_error`=1, `tx_byte` unchanged; go to BREAK.
- BREAK:
  - Wait until `rx_s`=1, then → IDLE.
  - A held-low line (break) produces exactly one `framing_error` and no further bytes.
- No flow control and no buffering. The consumer must accept `tx_byte` within one byte time (10·B cycles); the next pulse overwrites it.
- Reset:
  - state=IDLE, cnt=0, bit_idx=0, shift=0.
  - tx_byte=0, tx_new_byte=0, framing_error=0, busy=0, synchroniser flops=1.
  - Reset mid-frame aborts the frame with no pulse. Receive restarts on the next falling edge after reset deasserts.
- `reset` takes priority over all other events in the same cycle.

## Timing
- Start-bit check at t0+half_delay.
- Data bit k (0..7) sampled at t0+half_delay+(k+1)·B.
- Stop bit sampled at t0+half_delay+9·B.
- `tx_new_byte` or `framing_error` is high for exactly the single cycle t0+half_delay+9·B+1.
- Default parameters: sample at t0+6184, pulse at t0+6185; t0 is 2 cycles after the pin falls.
- `busy` rises at t0+1 and falls in the same cycle as the pulse.
- Back-to-back frames: the receiver is in IDLE half a bit before the nominal stop-bit end. It therefore accepts a new start edge arriving immediately after the stop bit.
- Tolerance: mid-bit sampling allows total sender/receiver rate error of about ±4.5% with the 2-cycle synchroniser skew.
- `tx_new_byte` and `framing_error` are never high in the same cycle.

## Test plan
Bench parameters for all scenarios: comm_clk_frequency=16, baud_rate=1, giving B=16 and half_delay=7.
- Reset, line idle high → all outputs 0 and `busy`=0 for 100 cycles. Then drive 0xA5 → `tx_new_byte` for one cycle at t0+152 with `tx_byte`=0xA5.
- 0x00, 0xFF, 0x55 back-to-back, with no idle between stop and the next start → three pulses 160 cycles apart carrying 0x00, 0xFF, 0x55; no `framing_error`.
- Pin low for 5 cycles, then high → no pulse, `busy` back to 0 by t0+8, `tx_byte` unchanged.
- Frame 0x3C with stop bit low, then line high → `framing_error` one cycle at t0+152, no `tx_new_byte`, `tx_byte` keeps its prior value. A following good 0x81 is received correctly.
- Line held low for 400 cycles, then released and 0x42 sent → exactly one `framing_error`, then `tx_byte`=0x42.
- `reset` asserted at t0+80 during a frame for 1 cycle → no pulse, `busy`=0 next cycle. A fresh 0x99 then decodes correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at mid-period
// and presents good bytes as a one-cycle pulse; a low stop bit reports a framing error.
module uart_receiver #(
  parameter int comm_clk_frequency = 75000000,
  parameter int baud_rate          = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       tx_new_byte,
  output logic [7:0] tx_byte,
  output logic       framing_error,
  output logic       busy
);

  localparam logic [15:0] BAUD_DELAY = 16'(comm_clk_frequency / baud_rate - 1);
  localparam logic [15:0] HALF_DELAY = BAUD_DELAY / 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_tx_byte;
  logic        r_tx_new_byte;
  logic        r_framing_error;
  logic        r_busy;
  logic        w_rx_s;

  assign w_rx_s        = r_sync[1];
  assign tx_new_byte   = r_tx_new_byte;
  assign tx_byte       = r_tx_byte;
  assign framing_error = r_framing_error;
  assign busy          = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_sync          <= 2'b11;
      r_cnt           <= 16'd0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'd0;
      r_tx_byte       <= 8'd0;
      r_tx_new_byte   <= 1'b0;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], uart_rx};
      r_tx_new_byte   <= 1'b0;
      r_framing_error <= 1'b0;
      r_cnt           <= r_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          // The cycle that first sees the low line is tick 0 of the start bit,
          // so START begins at 1 to keep all sample points on t0+half+k*B.
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= 16'd1;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == HALF_DELAY) begin
            r_cnt <= 16'd0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (r_cnt == BAUD_DELAY) begin
            r_cnt   <= 16'd0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (r_cnt == BAUD_DELAY) begin
            r_cnt <= 16'd0;
            if (w_rx_s) begin
              r_tx_byte     <= r_shift;
              r_tx_new_byte <= 1'b1;
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A held-low line stays here so it yields one error, not a stream of 0x00 bytes.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames with a frame-level
// scoreboard predicting pulse cycles, tx_byte and busy windows.
module tb_uart_receiver;

  localparam int CLKF = 16;
  localparam int BAUD = 1;
  localparam int B    = CLKF / BAUD;
  localparam int HALF = (B - 1) / 2;

  localparam int K_GOOD   = 0;
  localparam int K_FERR   = 1;
  localparam int K_GLITCH = 2;

  typedef struct {
    int         t0;
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       tx_new_byte;
  logic [7:0] tx_byte;
  logic       framing_error;
  logic       busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   newCount = 0;
  int   ferrCount = 0;
  int   lastNewCyc = -1;
  int   lastFerrCyc = -1;
  bit   modelOn = 1'b0;
  exp_t sb[$];

  logic [7:0] modelByte = 8'd0;
  logic       expNew;
  logic       expFerr;
  logic       busyKnown;
  logic       busyExp;

  uart_receiver #(
    .comm_clk_frequency(CLKF),
    .baud_rate(BAUD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .tx_new_byte(tx_new_byte),
    .tx_byte(tx_byte),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle in which a frame's outcome becomes visible (pulse, or busy dropping after a glitch).
  function automatic int endOf(input exp_t e);
    return (e.kind == K_GLITCH) ? e.t0 + HALF + 1 : e.t0 + HALF + 9 * B + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives one 8N1 frame starting now; pinFall is the cycle the start bit goes out.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit track, output int pinFall);
    logic [9:0] bits;
    exp_t       e;
    bits    = {stopBit, data, 1'b0};
    pinFall = cyc;
    if (track) begin
      e.t0   = cyc + 2;
      e.kind = stopBit ? K_GOOD : K_FERR;
      e.data = data;
      sb.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (B) tick();
    end
  endtask

  // Per-cycle comparison of the DUT against the frame scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      modelByte = 8'd0;
    end else if (modelOn) begin
      expNew    = 1'b0;
      expFerr   = 1'b0;
      busyKnown = 1'b0;
      busyExp   = 1'b0;
      foreach (sb[i]) begin
        if (cyc == endOf(sb[i]) && sb[i].kind == K_GOOD) begin
          expNew    = 1'b1;
          modelByte = sb[i].data;
        end
        if (cyc == endOf(sb[i]) && sb[i].kind == K_FERR) expFerr = 1'b1;
        if (cyc > sb[i].t0 && cyc < endOf(sb[i])) begin
          busyKnown = 1'b1;
          busyExp   = 1'b1;
        end else if (cyc == endOf(sb[i]) && sb[i].kind != K_FERR) begin
          busyKnown = 1'b1;
          busyExp   = 1'b0;
        end
      end
      checkOutput("tx_new_byte", {31'd0, tx_new_byte}, {31'd0, expNew});
      checkOutput("framing_error", {31'd0, framing_error}, {31'd0, expFerr});
      checkOutput("tx_byte", {24'd0, tx_byte}, {24'd0, modelByte});
      if (busyKnown) checkOutput("busy", {31'd0, busy}, {31'd0, busyExp});
      if (tx_new_byte === 1'b1) begin
        newCount++;
        lastNewCyc = cyc;
      end
      if (framing_error === 1'b1) begin
        ferrCount++;
        lastFerrCyc = cyc;
      end
      while (sb.size() > 0 && endOf(sb[0]) < cyc) void'(sb.pop_front());
    end
  end

  initial begin
    int   n;
    int   n1;
    int   n0;
    int   f0;
    exp_t e;

    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) tick();
    reset   = 1'b0;
    modelOn = 1'b1;

    // Quiet line after reset: every output stays at zero.
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("idle_outputs", {21'd0, busy, tx_new_byte, framing_error, tx_byte}, 32'd0);
    end

    // Single good byte.
    n0 = newCount;
    applyStimulus(8'hA5, 1'b1, 1'b1, n);
    repeat (10) tick();
    checkOutput("a5_count", newCount - n0, 1);
    checkOutput("a5_cycle", lastNewCyc - n, 154);
    checkOutput("a5_byte", {24'd0, tx_byte}, 32'hA5);

    // Back-to-back frames with no idle gap.
    n0 = newCount;
    f0 = ferrCount;
    applyStimulus(8'h00, 1'b1, 1'b1, n1);
    applyStimulus(8'hFF, 1'b1, 1'b1, n);
    applyStimulus(8'h55, 1'b1, 1'b1, n);
    repeat (10) tick();
    checkOutput("b2b_count", newCount - n0, 3);
    checkOutput("b2b_ferr", ferrCount - f0, 0);
    checkOutput("b2b_last_cycle", lastNewCyc - n1, 474);
    checkOutput("b2b_byte", {24'd0, tx_byte}, 32'h55);

    // Short low glitch: rejected at the start-bit check.
    n0 = newCount;
    n  = cyc;
    e.t0 = n + 2;
    e.kind = K_GLITCH;
    e.data = 8'h00;
    sb.push_back(e);
    uart_rx = 1'b0;
    repeat (5) tick();
    uart_rx = 1'b1;
    repeat (5) tick();
    checkOutput("glitch_busy", {31'd0, busy}, 0);
    repeat (10) tick();
    checkOutput("glitch_count", newCount - n0, 0);
    checkOutput("glitch_byte", {24'd0, tx_byte}, 32'h55);

    // Low stop bit, then a good byte.
    n0 = newCount;
    f0 = ferrCount;
    applyStimulus(8'h3C, 1'b0, 1'b1, n);
    uart_rx = 1'b1;
    repeat (20) tick();
    checkOutput("ferr_count", ferrCount - f0, 1);
    checkOutput("ferr_cycle", lastFerrCyc - n, 154);
    checkOutput("ferr_no_byte", newCount - n0, 0);
    checkOutput("ferr_byte_kept", {24'd0, tx_byte}, 32'h55);
    applyStimulus(8'h81, 1'b1, 1'b1, n);
    repeat (10) tick();
    checkOutput("after_ferr_byte", {24'd0, tx_byte}, 32'h81);

    // Break: line held low for 400 cycles.
    n0 = newCount;
    f0 = ferrCount;
    n  = cyc;
    e.t0 = n + 2;
    e.kind = K_FERR;
    e.data = 8'h00;
    sb.push_back(e);
    uart_rx = 1'b0;
    repeat (400) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    applyStimulus(8'h42, 1'b1, 1'b1, n);
    repeat (10) tick();
    checkOutput("break_ferr_count", ferrCount - f0, 1);
    checkOutput("break_byte_count", newCount - n0, 1);
    checkOutput("break_byte", {24'd0, tx_byte}, 32'h42);

    // Reset in the middle of a frame; the trailing bits of 0xF0 are all high.
    n0 = newCount;
    fork
      begin
        int nA;
        applyStimulus(8'hF0, 1'b1, 1'b0, nA);
      end
      begin
        repeat (82) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 0);
        checkOutput("abort_byte", {24'd0, tx_byte}, 0);
      end
    join
    repeat (10) tick();
    checkOutput("abort_count", newCount - n0, 0);
    applyStimulus(8'h99, 1'b1, 1'b1, n);
    repeat (10) tick();
    checkOutput("post_abort_count", newCount - n0, 1);
    checkOutput("post_abort_byte", {24'd0, tx_byte}, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
